// File: rtl/vm_pkg.sv
// vm_pkg: controller state encoding, timer width and the item price table.
package vm_pkg;
  typedef enum logic [2:0] {IDLE, RELOADING, WAIT_KEY1, WAIT_KEY2, CHECK, WAIT_TRAN, VEND_S, DOOR_S} vm_state_t;
  localparam int TMR_W = 8;
  function automatic logic [2:0] vm_price(input logic [7:0] code);
    return code < 8'd4  ? 3'd1 :
           code < 8'd8  ? 3'd2 :
           code < 8'd12 ? 3'd3 :
           code < 8'd16 ? 3'd4 :
           code < 8'd18 ? 3'd5 :
           code < 8'd20 ? 3'd6 : 3'd7;
  endfunction
endpackage

// File: rtl/vm_timer.sv
// vm_timer: loadable down-counter that stops at zero; one instance serves every timed state.
module vm_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] value;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) value <= '0;
    else if (load) value <= load_val;
    else if (dec && value != '0) value <= value - W'(1);
  assign zero = value == '0;
endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param: card-payment vending controller with per-slot stock and timed windows.
// Optional sales counter output SALES_TOTAL is built when VM_SALES_CNT_EN is defined.
module vending_machine_param
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS  = 20,
  parameter int STOCK_W    = 4,
  parameter int RELOAD_QTY = 10,
  parameter int COST_W     = 3,
  parameter int KEY_TMO    = 5,
  parameter int TRAN_TMO   = 5,
  parameter int DOOR_TMO   = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CARD_IN,
  input  logic              RELOAD,
  input  logic              KEY_PRESS,
  input  logic [3:0]        ITEM_CODE,
  input  logic              VALID_TRAN,
  input  logic              DOOR_OPEN,
  output logic              VEND,
  output logic              INVALID_SEL,
  output logic              FAILED_TRAN,
  output logic [COST_W-1:0] COST,
  output logic              BUSY
`ifdef VM_SALES_CNT_EN
  , output logic [15:0]     SALES_TOTAL
`endif
);
  vm_state_t state, state_n;
  logic [STOCK_W-1:0] stock [NUM_ITEMS];
  logic [STOCK_W-1:0] sel_stock;
  logic [3:0] key1, key2;
  logic [7:0] code;
  logic [TMR_W-1:0] tmr_val;
  logic key_q, key_edge, tmo, sel_ok, vend_ev;
  assign key_edge = KEY_PRESS & ~key_q;
  assign code = 8'(key1) * 8'd10 + 8'(key2);
  assign vend_ev = state == WAIT_TRAN && VALID_TRAN;
  always_comb begin
    sel_stock = '0;
    for (int i = 0; i < NUM_ITEMS; i++) if (code == 8'(i)) sel_stock = stock[i];
  end
  assign sel_ok = key1 <= 4'd9 && key2 <= 4'd9 && code < 8'(NUM_ITEMS) && sel_stock != '0;
  // an event always beats a coincident timeout
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = RELOAD ? RELOADING : CARD_IN ? WAIT_KEY1 : IDLE;
      RELOADING: state_n = RELOAD ? RELOADING : IDLE;
      WAIT_KEY1: state_n = key_edge ? WAIT_KEY2 : tmo ? IDLE : WAIT_KEY1;
      WAIT_KEY2: state_n = key_edge ? CHECK : tmo ? IDLE : WAIT_KEY2;
      CHECK:     state_n = sel_ok ? WAIT_TRAN : IDLE;
      WAIT_TRAN: state_n = VALID_TRAN ? VEND_S : tmo ? IDLE : WAIT_TRAN;
      VEND_S:    state_n = DOOR_OPEN ? DOOR_S : tmo ? IDLE : VEND_S;
      DOOR_S:    state_n = DOOR_OPEN ? DOOR_S : IDLE;
      default:   state_n = IDLE;
    endcase
  end
  assign tmr_val = state_n == WAIT_TRAN ? TMR_W'(TRAN_TMO) :
                   state_n == VEND_S    ? TMR_W'(DOOR_TMO) : TMR_W'(KEY_TMO);
  vm_timer #(.W(TMR_W)) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (state_n != state),
    .load_val (tmr_val),
    .dec      (1'b1),
    .zero     (tmo)
  );
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state       <= IDLE;
      key_q       <= 1'b0;
      key1        <= '0;
      key2        <= '0;
      VEND        <= 1'b0;
      INVALID_SEL <= 1'b0;
      FAILED_TRAN <= 1'b0;
      COST        <= '0;
      BUSY        <= 1'b0;
    end else begin
      state       <= state_n;
      key_q       <= KEY_PRESS;
      if (state == WAIT_KEY1 && key_edge) key1 <= ITEM_CODE;
      if (state == WAIT_KEY2 && key_edge) key2 <= ITEM_CODE;
      VEND        <= state_n == VEND_S || state_n == DOOR_S;
      INVALID_SEL <= state == CHECK && !sel_ok;
      FAILED_TRAN <= state == WAIT_TRAN && !VALID_TRAN && tmo;
      COST        <= state == CHECK && sel_ok ? COST_W'(vm_price(code)) : state_n == IDLE ? '0 : COST;
      BUSY        <= state_n != IDLE;
    end
  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_slot
    always_ff @(posedge CLK or posedge RESET)
      if (RESET) stock[i] <= '0;
      else if (state == RELOADING) stock[i] <= STOCK_W'(RELOAD_QTY);
      else if (vend_ev && code == 8'(i)) stock[i] <= stock[i] - STOCK_W'(1);
  end
`ifdef VM_SALES_CNT_EN
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) SALES_TOTAL <= '0;
    else if (vend_ev && SALES_TOTAL != 16'hFFFF) SALES_TOTAL <= SALES_TOTAL + 16'd1;
`endif
endmodule
